// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_sequencer
//  Description : Canal-lock chamber controller. Latches boat requests from
//                the low and high sides, sequences gates and valves through
//                gate / fill / drain phases, and times each phase with an
//                external countdown timer (start/seconds/done handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_sequencer #(
    parameter logic [9:0] FILL_SEC  = 10'd420,
    parameter logic [9:0] DRAIN_SEC = 10'd480,
    parameter logic [9:0] GATE_SEC  = 10'd300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arriveLow,
    input  logic       arriveHigh,
    input  logic       timerDone,
    output logic       timerStart,
    output logic [9:0] timerSeconds,
    output logic       lowGate,
    output logic       highGate,
    output logic       fillValve,
    output logic       drainValve,
    output logic       levelHigh,
    output logic       busy,
    output logic       pendLow,
    output logic       pendHigh
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPEN_LOW  = 3'd1,
        S_FILL      = 3'd2,
        S_OPEN_HIGH = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    // Served-side encoding held in dir
    localparam logic c_DIR_LOW  = 1'b0;
    localparam logic c_DIR_HIGH = 1'b1;

    state_t state_q, state_d;
    logic   level_q, level_d;
    logic   dir_q, dir_d;
    logic   pend_low_q, pend_low_d;
    logic   pend_high_q, pend_high_d;
    logic   first_q, first_d;

    logic   w_busy;
    logic   w_phase_done;
    logic   w_final_gate;
    logic   w_req_low;
    logic   w_req_high;

    // Next-state, request latching and level tracking
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        dir_d       = dir_q;
        pend_low_d  = pend_low_q;
        pend_high_d = pend_high_q;

        w_busy = (state_q != S_IDLE);
        // timerDone still reflects the previous phase in the first cycle
        w_phase_done = w_busy && !first_q && timerDone;
        // The gate that lets the boat out ends the transit
        w_final_gate = ((state_q == S_OPEN_HIGH) && (dir_q == c_DIR_LOW)) ||
                       ((state_q == S_OPEN_LOW)  && (dir_q == c_DIR_HIGH));

        w_req_low  = pend_low_q  | arriveLow;
        w_req_high = pend_high_q | arriveHigh;

        // A side already being served does not re-arm its own request
        if (arriveLow && !(w_busy && (dir_q == c_DIR_LOW))) begin
            pend_low_d = 1'b1;
        end
        if (arriveHigh && !(w_busy && (dir_q == c_DIR_HIGH))) begin
            pend_high_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (level_q) begin
                    // Chamber is up: the high side is served without a level change
                    if (w_req_high) begin
                        state_d = S_OPEN_HIGH;
                        dir_d   = c_DIR_HIGH;
                    end else if (w_req_low) begin
                        state_d = S_DRAIN;
                        dir_d   = c_DIR_LOW;
                    end
                end else begin
                    if (w_req_low) begin
                        state_d = S_OPEN_LOW;
                        dir_d   = c_DIR_LOW;
                    end else if (w_req_high) begin
                        state_d = S_FILL;
                        dir_d   = c_DIR_HIGH;
                    end
                end
            end
            S_OPEN_LOW: begin
                if (w_phase_done) begin
                    state_d = (dir_q == c_DIR_HIGH) ? S_IDLE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_phase_done) begin
                    state_d = S_OPEN_HIGH;
                    level_d = 1'b1;
                end
            end
            S_OPEN_HIGH: begin
                if (w_phase_done) begin
                    state_d = (dir_q == c_DIR_LOW) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_phase_done) begin
                    state_d = S_OPEN_LOW;
                    level_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_phase_done && w_final_gate) begin
            if (dir_q == c_DIR_HIGH) begin
                pend_high_d = 1'b0;
            end else begin
                pend_low_d = 1'b0;
            end
        end

        // Every non-idle state is timed, so any entry into one loads the timer
        first_d = (state_d != state_q) && (state_d != S_IDLE);
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            level_q     <= 1'b0;
            dir_q       <= c_DIR_LOW;
            pend_low_q  <= 1'b0;
            pend_high_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            dir_q       <= dir_d;
            pend_low_q  <= pend_low_d;
            pend_high_q <= pend_high_d;
            first_q     <= first_d;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        lowGate      = (state_q == S_OPEN_LOW);
        highGate     = (state_q == S_OPEN_HIGH);
        fillValve    = (state_q == S_FILL);
        drainValve   = (state_q == S_DRAIN);
        busy         = (state_q != S_IDLE);
        timerStart   = first_q && (state_q != S_IDLE);
        levelHigh    = level_q;
        pendLow      = pend_low_q;
        pendHigh     = pend_high_q;
        case (state_q)
            S_OPEN_LOW,
            S_OPEN_HIGH: timerSeconds = GATE_SEC;
            S_FILL:      timerSeconds = FILL_SEC;
            S_DRAIN:     timerSeconds = DRAIN_SEC;
            default:     timerSeconds = 10'd0;
        endcase
    end

endmodule
`default_nettype wire
